alu_host_ctrl: RTL
==================

ALU_HOST_CTRL -- requirements
Module: alu_host_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles WAIT holds for alu_done before an error response (range 2..255).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered by upstream.
REQ-005 cmd_ready  output  1  block accepts command this cycle.
REQ-006 cmd_op  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 alu_start  output  1  one-cycle start pulse to ALU.
REQ-010 alu_op_code  output  2  registered opcode to ALU.
REQ-011 alu_operand_A  output  8  registered operand A to ALU.
REQ-012 alu_operand_B  output  8  registered operand B to ALU.
REQ-013 alu_result  input  16  ALU result; div = {remainder, quotient}.
REQ-014 alu_done  input  1  ALU completion indication.
REQ-015 rsp_valid  output  1  response available.
REQ-016 rsp_ready  input  1  downstream accepts response.
REQ-017 rsp_data  output  16  captured result; 0x0000 on error.
REQ-018 rsp_op  output  2  opcode of the command that produced the response.
REQ-019 rsp_err  output  1  1 = timeout, rsp_data invalid.
REQ-020 busy  output  1  high in any state other than IDLE.
REQ-021 done_count  output  8  completed responses (ok or error), wraps 255->0.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one active.
REQ-023 IDLE: cmd_ready=1; cmd_valid&cmd_ready -> latch cmd_op/a/b into alu_op_code/alu_operand_A/alu_operand_B, go ISSUE.
REQ-024 cmd_ready SHALL be 0 in ISSUE, WAIT, RESP; no command buffering.
REQ-025 ISSUE: alu_start=1 for exactly this one cycle; timeout counter cleared; next state WAIT unconditionally.
REQ-026 alu_op_code/operands SHALL stay stable from ISSUE until return to IDLE.
REQ-027 alu_done is ignored in IDLE, ISSUE and RESP.
REQ-028 WAIT: alu_done=1 -> capture alu_result into rsp_data, rsp_err=0, go RESP in the next cycle.
REQ-029 WAIT: counter increments each cycle with alu_done=0; on reaching TIMEOUT_CYCLES -> rsp_data=0x0000, rsp_err=1, go RESP.
REQ-030 If alu_done=1 in the cycle the counter reaches TIMEOUT_CYCLES, done wins (rsp_err=0).
REQ-031 Minimum latency: accept cycle N, alu_start at N+1, rsp_valid at N+3 if alu_done high at N+2.
REQ-032 RESP: rsp_valid=1, rsp_data/rsp_op/rsp_err held stable until rsp_valid&rsp_ready.
REQ-033 On handshake: done_count+1 (mod 256), go IDLE; next command accepted no earlier than the following cycle.
REQ-034 rsp_ready high outside RESP SHALL have no effect.
REQ-035 busy = (state != IDLE), combinational from state.

Reset
REQ-036 reset SHALL asynchronously force IDLE from any state, including mid-WAIT and mid-RESP; in-flight command and response discarded.
REQ-037 Reset values: cmd_ready=1 once state=IDLE, alu_start=0, alu_op_code=00, alu_operand_A/B=0x00, rsp_valid=0, rsp_data=0x0000, rsp_op=00, rsp_err=0, busy=0, done_count=0x00, timeout counter=0.
REQ-038 First command after reset release is accepted on the first rising edge with cmd_valid=1 and reset=0.

Verification
REQ-039 ADD 20+15, ALU done 1 cycle after start, rsp_ready=1 -> one alu_start pulse, rsp_data=0x0023, rsp_op=00, rsp_err=0, done_count=1.
REQ-040 MUL 7*6 with done after 9 cycles, rsp_ready low 5 cycles -> rsp_data=0x002A held stable, rsp_valid held, cmd_ready=0 until handshake.
REQ-041 DIV 200/13 -> rsp_data=0x050F (rem 5, quot 15), rsp_op=11.
REQ-042 alu_done never asserted, TIMEOUT_CYCLES=64 -> rsp_valid 64 cycles into WAIT with rsp_err=1, rsp_data=0x0000; done_count increments.
REQ-043 Reset asserted during WAIT, then SUB 30-10 -> no response for aborted op, rsp_data=0x0014, done_count=1.
REQ-044 256 back-to-back ADDs with cmd_valid held high -> no alu_start while busy, one start per command, done_count wraps to 0x00.

Source files
------------

// File: rtl/alu_host_ctrl.sv
// Host-side controller for a multi-cycle ALU.
// Accepts one command at a time, issues it to the ALU and waits for completion
// or timeout, then holds the response until downstream takes it.
module alu_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic        alu_start,
  output logic [1:0]  alu_op_code,
  output logic [7:0]  alu_operand_A,
  output logic [7:0]  alu_operand_B,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_op,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  done_count
);

  // Last count value of WAIT; the cycle that would bring the counter to
  // TIMEOUT_CYCLES is the one that times out.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  rop_q, rop_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  // Next-state and datapath capture decisions.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    rop_d   = rop_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          state_d = StIssue;
        end
      end
      StIssue: begin
        tmo_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over a simultaneous timeout.
        if (alu_done) begin
          data_d  = alu_result;
          err_d   = 1'b0;
          rop_d   = op_q;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          tmo_d   = tmo_q + 8'd1;
          data_d  = 16'h0000;
          err_d   = 1'b1;
          rop_d   = op_q;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and captured-data registers; reset discards any in-flight work.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      tmo_q   <= 8'd0;
      op_q    <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      data_q  <= 16'h0000;
      rop_q   <= 2'd0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      rop_q   <= rop_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign alu_start     = (state_q == StIssue);
  assign rsp_valid     = (state_q == StResp);
  assign busy          = (state_q != StIdle);
  assign alu_op_code   = op_q;
  assign alu_operand_A = a_q;
  assign alu_operand_B = b_q;
  assign rsp_data      = data_q;
  assign rsp_op        = rop_q;
  assign rsp_err       = err_q;
  assign done_count    = cnt_q;

endmodule
